// File: rtl/result_reader.sv
// result_reader
//   Drains the dot-product result RAM and streams the stored words out over a
//   valid/ready interface. A start request latches a base address and a run
//   length. Sequential reads are then issued to the single-port RAM, which has
//   a 1-cycle read latency. Returned words land in a 2-entry FIFO, so
//   downstream backpressure never loses data.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active low
//   start      in   run request, sampled only while idle
//   base_addr  in   first RAM address of the run (ADDR_W)
//   len        in   words to read, 0..2^ADDR_W (ADDR_W+1)
//   busy       out  high while a run is in progress
//   done       out  one-cycle pulse at the end of a run
//   ram_ren    out  RAM read strobe
//   ram_addr   out  RAM read address (ADDR_W)
//   ram_rdata  in   RAM read data, valid the cycle after ram_ren (DATA_W)
//   out_valid  out  FIFO head is valid
//   out_ready  in   downstream accepts the head word
//   out_data   out  FIFO head word (DATA_W)
//   out_last   out  head word is the final word of the run
module result_reader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              ram_ren,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_FIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   issued_q, issued_d;
  logic              infl_q, infl_d;
  logic              infl_last_q, infl_last_d;
  logic [1:0]        occ_q, occ_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        tag_q;
  logic [DATA_W-1:0] mem_q [2];

  logic              push, pop, head_last, credit_ok;
  logic [1:0]        pending;

  // A word returns from the RAM one cycle after every read strobe.
  assign push      = infl_q;
  assign out_valid = (occ_q != 2'd0);
  assign pop       = out_valid & out_ready;
  assign head_last = tag_q[rd_ptr_q];
  assign out_last  = out_valid & head_last;
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN);

  // Buffered words plus a read in flight must never exceed the two FIFO slots.
  // A pop in this cycle frees a slot in time for the next return.
  assign pending   = occ_q + {1'b0, infl_q};
  assign credit_ok = (pending < 2'd2) || ((pending == 2'd2) && pop);

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    issued_d    = issued_q;
    infl_last_d = 1'b0;
    ram_ren     = 1'b0;
    ram_addr    = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d   = base_addr;
          len_d    = len;
          issued_d = '0;
          state_d  = (len != '0) ? S_READ : S_FIN;
        end
      end
      S_READ: begin
        if ((issued_q < len_q) && credit_ok) begin
          ram_ren     = 1'b1;
          // The address wraps naturally modulo 2^ADDR_W.
          ram_addr    = base_q + issued_q[ADDR_W-1:0];
          issued_d    = issued_q + 1'b1;
          infl_last_d = (issued_d == len_q);
          if (issued_d == len_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && head_last) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign infl_d   = ram_ren;
  assign wr_ptr_d = wr_ptr_q ^ push;
  assign rd_ptr_d = rd_ptr_q ^ pop;

  always_comb begin
    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      occ_q       <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      tag_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      occ_q       <= occ_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      if (push) tag_q[wr_ptr_q] <= infl_last_q;
    end
  end

  // FIFO payload needs no reset: out_data is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= ram_rdata;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst && push && !pop)
      assert (occ_q != 2'd2) else $error("result_reader: FIFO overflow");
  end
`endif

endmodule
